// File: rtl/io_port_bridge.sv
// CPU I/O request bridge: routes one out/in request at a time to a per-port
// Decoupled device interface, with handshake timeout and a one-cycle response.
module io_port_bridge #(
  parameter int NUM_PORTS = 4,
  parameter int DEV_W     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  input  logic                       i_req_write,
  input  logic [7:0]                 i_req_port,
  input  logic [31:0]                i_req_data,
  output logic                       o_req_ready,
  output logic                       o_resp_valid,
  output logic [31:0]                o_resp_data,
  output logic                       o_resp_err,
  output logic [NUM_PORTS-1:0]       o_dev_din_valid,
  output logic [NUM_PORTS*DEV_W-1:0] o_dev_din_bits,
  input  logic [NUM_PORTS-1:0]       i_dev_din_ready,
  input  logic [NUM_PORTS-1:0]       i_dev_dout_valid,
  input  logic [NUM_PORTS*DEV_W-1:0] i_dev_dout_bits,
  output logic [NUM_PORTS-1:0]       o_dev_dout_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [7:0]  PORTS_C   = 8'(NUM_PORTS);

  state_t               state_q;
  logic [7:0]           port_q;
  logic [DEV_W-1:0]     data_q;
  logic                 write_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [31:0]          resp_data_q;
  logic                 resp_err_q;

  logic [NUM_PORTS-1:0] sel;
  logic [DEV_W-1:0]     rd_bits;
  logic                 hs;
  logic                 unused_req_data;

  assign unused_req_data = ^i_req_data;

  // One-hot decode of the latched port; out-of-range ports select nothing.
  always_comb begin
    sel     = '0;
    rd_bits = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel[p] = (port_q == 8'(p));
      if (sel[p]) rd_bits = i_dev_dout_bits[p*DEV_W +: DEV_W];
    end
  end

  assign hs    = write_q ? |(sel & i_dev_din_ready) : |(sel & i_dev_dout_valid);
  assign cnt_d = cnt_q + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      port_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            port_q      <= i_req_port;
            data_q      <= i_req_data[DEV_W-1:0];
            write_q     <= i_req_write;
            cnt_q       <= '0;
            resp_data_q <= '0;
            if (i_req_port >= PORTS_C) begin
              resp_err_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              state_q <= i_req_write ? S_WRITE : S_READ;
            end
          end
        end
        S_WRITE, S_READ: begin
          // A handshake on the final allowed cycle beats the timeout.
          if (hs) begin
            resp_err_q  <= 1'b0;
            resp_data_q <= write_q ? 32'd0 : 32'(rd_bits);
            state_q     <= S_RESP;
          end else if (cnt_q == TIMEOUT_C) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          resp_err_q  <= 1'b0;
          resp_data_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready      = (state_q == S_IDLE) && !i_rst;
  assign o_resp_valid     = (state_q == S_RESP);
  assign o_resp_data      = resp_data_q;
  assign o_resp_err       = resp_err_q;
  assign o_dev_din_valid  = (state_q == S_WRITE) ? sel : '0;
  assign o_dev_dout_ready = (state_q == S_READ)  ? sel : '0;

  always_comb begin
    o_dev_din_bits = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state_q == S_WRITE && sel[p]) o_dev_din_bits[p*DEV_W +: DEV_W] = data_q;
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Randomized and directed bench for io_port_bridge against a transaction-level
// timing model (response cycle and contents computed from the handshake delay).
module tb_io_port_bridge;
  localparam int NP  = 4;
  localparam int DW  = 8;
  localparam int TO  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_write;
  logic [7:0]     req_port;
  logic [31:0]    req_data;
  logic           req_ready, resp_valid, resp_err;
  logic [31:0]    resp_data;
  logic [NP-1:0]  din_valid, din_ready, dout_valid, dout_ready;
  logic [NP*DW-1:0] din_bits, dout_bits;

  int n_checks = 0;
  int n_errors = 0;

  io_port_bridge #(.NUM_PORTS(NP), .DEV_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_port(req_port), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_resp_valid(resp_valid),
    .o_resp_data(resp_data), .o_resp_err(resp_err),
    .o_dev_din_valid(din_valid), .o_dev_din_bits(din_bits),
    .i_dev_din_ready(din_ready), .i_dev_dout_valid(dout_valid),
    .i_dev_dout_bits(dout_bits), .o_dev_dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise();
    din_ready  = NP'($urandom);
    dout_valid = NP'($urandom);
    dout_bits  = (NP*DW)'($urandom);
  endtask

  // Runs one request. d = transfer cycle (0-based) at which the selected
  // device raises ready/valid and holds it; d > TO means never in time.
  task automatic run_txn(input int p, input bit wr, input logic [31:0] data,
                         input int d, input logic [7:0] rdval);
    bit good;
    int resp_cyc;
    bit exp_err;
    logic [31:0] exp_data;
    logic [NP-1:0] onehot;
    good     = (p < NP);
    onehot   = good ? NP'(1 << p) : '0;
    if (!good) begin
      resp_cyc = 1; exp_err = 1'b1; exp_data = 0;
    end else if (d <= TO) begin
      resp_cyc = d + 2; exp_err = 1'b0; exp_data = wr ? 32'd0 : {24'd0, rdval};
    end else begin
      resp_cyc = TO + 2; exp_err = 1'b1; exp_data = 0;
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_port = 8'(p); req_data = data;
    noise();
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    check("resp_valid_idle", 64'(resp_valid), 64'd0);

    for (int c = 1; c <= resp_cyc; c++) begin
      bit xfer;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_port  = 8'($urandom);
      req_data  = $urandom;
      noise();
      if (good) begin
        if (wr) din_ready[p] = (c - 1 >= d);
        else begin
          dout_valid[p]          = (c - 1 >= d);
          dout_bits[p*DW +: DW]  = rdval;
        end
      end
      xfer = good && (c < resp_cyc);
      @(negedge clk);
      check("req_ready_busy", 64'(req_ready), 64'd0);
      check("din_valid",  64'(din_valid),  64'((xfer && wr)  ? onehot : '0));
      check("dout_ready", 64'(dout_ready), 64'((xfer && !wr) ? onehot : '0));
      check("din_bits",   64'(din_bits),
            64'((xfer && wr) ? ((NP*DW)'(data[7:0]) << (p*DW)) : '0));
      check("resp_valid", 64'(resp_valid), 64'(c == resp_cyc));
      check("resp_err",   64'(resp_err),   64'((c == resp_cyc) ? exp_err : 1'b0));
      check("resp_data",  64'(resp_data),  64'((c == resp_cyc) ? exp_data : 32'd0));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_port = '0; req_data = '0;
    din_ready = '0; dout_valid = '0; dout_bits = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp", 64'({resp_valid, resp_err, resp_data}), 64'd0);
    check("rst_dev", 64'({din_valid, din_bits, dout_ready}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", 64'(req_ready), 64'd1);

    // Directed cases.
    run_txn(0, 1'b1, 32'h0000_00A5, 0, 8'h00);
    run_txn(2, 1'b0, 32'h0, 3, 8'h3C);
    run_txn(7, 1'b1, 32'h1234_5678, 0, 8'h00);
    run_txn(1, 1'b1, 32'h0000_0055, 99, 8'h00);
    run_txn(1, 1'b1, 32'h0000_0055, 3, 8'h00);
    run_txn(3, 1'b0, 32'h0, 4, 8'h77);

    // Reset during a READ on port 3.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_port = 8'd3; req_data = '0;
    din_ready = '0; dout_valid = '0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check("rd3_dout_ready", 64'(dout_ready), 64'h8);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready_hi", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_abort_dout_ready", 64'(dout_ready), 64'd0);
    check("rst_abort_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_abort_resp2", 64'(resp_valid), 64'd0);
    check("req_ready_after_abort", 64'(req_ready), 64'd1);
    run_txn(2, 1'b1, 32'h0000_00C3, 1, 8'h00);

    // Randomized requests, including illegal ports and timeouts.
    for (int i = 0; i < 60; i++) begin
      run_txn(int'($urandom_range(0, 6)), 1'($urandom), $urandom,
              int'($urandom_range(0, 5)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
